// File: rtl/leaf_request_merger_if.sv
// Request-merger bus: two tree leaf channels in, one merged leaf request out.
// The "slave" modport is the merger itself; "master" is the tree/reader side.
interface leaf_request_merger_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int TAG_WIDTH     = 10
);
  logic [ADDRESS_WIDTH-1:0] leaf_index;
  logic                     receiver_en;
  logic [ADDRESS_WIDTH-1:0] leaf_index_two;
  logic                     receiver_two_en;
  logic                     out_ready;
  logic                     out_valid;
  logic [ADDRESS_WIDTH-1:0] out_leaf;
  logic                     out_chan;
  logic [TAG_WIDTH-1:0]     out_tag;
  logic                     clear_overflow;
  logic                     overflow;
  logic                     busy;

  modport master (
    output leaf_index, receiver_en, leaf_index_two, receiver_two_en,
    output out_ready, clear_overflow,
    input  out_valid, out_leaf, out_chan, out_tag, overflow, busy
  );

  modport slave (
    input  leaf_index, receiver_en, leaf_index_two, receiver_two_en,
    input  out_ready, clear_overflow,
    output out_valid, out_leaf, out_chan, out_tag, overflow, busy
  );
endinterface

// File: rtl/leaf_request_merger.sv
// Merges two tagged leaf streams through per-channel FIFOs into one registered, round-robin output.
// Latency 2 edges from enable to out_valid; out_ready low stalls the output, then the FIFOs, then drops (sticky overflow).
module leaf_request_merger #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int TAG_WIDTH     = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  leaf_request_merger_if.slave  bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [ADDRESS_WIDTH-1:0] r_leaf_mem [2][FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]     r_tag_mem  [2][FIFO_DEPTH];
  logic [PW-1:0]            r_wptr     [2];
  logic [PW-1:0]            r_rptr     [2];
  logic [CW-1:0]            r_cnt      [2];
  logic [TAG_WIDTH-1:0]     r_tag_ctr  [2];

  logic                     r_last_grant;
  logic                     r_out_valid;
  logic                     r_out_chan;
  logic [ADDRESS_WIDTH-1:0] r_out_leaf;
  logic [TAG_WIDTH-1:0]     r_out_tag;
  logic                     r_overflow;

  logic                     w_en   [2];
  logic [ADDRESS_WIDTH-1:0] w_leaf [2];
  logic                     w_ne   [2];
  logic                     w_full [2];
  logic                     w_pop  [2];
  logic                     w_push [2];
  logic                     w_drop [2];
  logic                     w_load;
  logic                     w_gnt_vld;
  logic                     w_gnt;

  always_comb begin
    w_en[0]   = bus.receiver_en;
    w_en[1]   = bus.receiver_two_en;
    w_leaf[0] = bus.leaf_index;
    w_leaf[1] = bus.leaf_index_two;
    w_load    = !r_out_valid || bus.out_ready;
    w_ne[0]   = (r_cnt[0] != '0);
    w_ne[1]   = (r_cnt[1] != '0);
    w_gnt_vld = w_load && (w_ne[0] || w_ne[1]);
    // On a tie the channel that did not win last time goes next.
    w_gnt     = (w_ne[0] && w_ne[1]) ? ~r_last_grant : w_ne[1];
    for (int c = 0; c < 2; c++) begin
      w_full[c] = (r_cnt[c] == FULL);
      w_pop[c]  = w_gnt_vld && (w_gnt == 1'(c));
      w_push[c] = w_en[c] && (!w_full[c] || w_pop[c]);
      w_drop[c] = w_en[c] && w_full[c] && !w_pop[c];
    end
  end

  // Storage needs no reset; occupancy counts decide what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (w_push[c]) begin
        r_leaf_mem[c][r_wptr[c]] <= w_leaf[c];
        r_tag_mem[c][r_wptr[c]]  <= r_tag_ctr[c];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        r_wptr[c]    <= '0;
        r_rptr[c]    <= '0;
        r_cnt[c]     <= '0;
        r_tag_ctr[c] <= '0;
      end
      r_last_grant <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_chan   <= 1'b0;
      r_out_leaf   <= '0;
      r_out_tag    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_en[c]) r_tag_ctr[c] <= r_tag_ctr[c] + TAG_WIDTH'(1);
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + PW'(1);
        if (w_pop[c]) r_rptr[c] <= r_rptr[c] + PW'(1);
        if (w_push[c] && !w_pop[c]) r_cnt[c] <= r_cnt[c] + CW'(1);
        else if (!w_push[c] && w_pop[c]) r_cnt[c] <= r_cnt[c] - CW'(1);
      end
      if (w_load) begin
        r_out_valid <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_out_chan   <= w_gnt;
          r_out_leaf   <= r_leaf_mem[w_gnt][r_rptr[w_gnt]];
          r_out_tag    <= r_tag_mem[w_gnt][r_rptr[w_gnt]];
          r_last_grant <= w_gnt;
        end
      end
      // A fresh drop wins over a clear in the same cycle.
      if (w_drop[0] || w_drop[1]) r_overflow <= 1'b1;
      else if (bus.clear_overflow) r_overflow <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;
  assign bus.out_leaf  = r_out_leaf;
  assign bus.out_tag   = r_out_tag;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = w_ne[0] || w_ne[1] || r_out_valid;
endmodule
